// File: rtl/decoder_scoreboard.sv
// Registered one-hot decoder alongside a busy-bit scoreboard that tracks pending writes.
// Issue sets a busy bit, writeback clears it, and both source operands are hazard-checked.
module decoder_scoreboard #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dec_en,
    input  logic [ADDR_W-1:0]      dec_addr,
    output logic [2**ADDR_W-1:0]   dec_onehot,
    output logic                   dec_valid,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_addr,
    output logic                   issue_stall,
    input  logic                   wb_en,
    input  logic [ADDR_W-1:0]      wb_addr,
    output logic                   wb_err,
    input  logic [ADDR_W-1:0]      rs_addr,
    input  logic [ADDR_W-1:0]      rt_addr,
    output logic                   rs_hazard,
    output logic                   rt_hazard,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [ADDR_W:0]        busy_count
);

    localparam int unsigned N  = 2**ADDR_W;
    localparam int unsigned CW = ADDR_W + 1;

    logic [N-1:0]  dec_onehot_q, dec_onehot_d;
    logic          dec_valid_q, dec_valid_d;
    logic [N-1:0]  busy_q, busy_d;
    logic [CW-1:0] busy_count_q, busy_count_d;
    logic          wb_err_q, wb_err_d;

    logic issue_ok, wb_ok, wb_hits_issue, issue_accept;

    // Index 0 is hardwired "never pending" when ZERO_REG is set.
    function automatic logic idx_ok(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        dec_onehot_d = '0;
        dec_valid_d  = dec_en;
        if (dec_en && idx_ok(dec_addr)) begin
            dec_onehot_d[dec_addr] = 1'b1;
        end
    end

    always_comb begin
        issue_ok      = issue_en && idx_ok(issue_addr);
        wb_ok         = wb_en && idx_ok(wb_addr);
        wb_hits_issue = wb_ok && (wb_addr == issue_addr);
        issue_stall   = issue_ok && busy_q[issue_addr] && !wb_hits_issue;
        issue_accept  = issue_ok && !issue_stall;

        busy_d   = busy_q;
        wb_err_d = wb_ok && !busy_q[wb_addr];
        if (wb_ok && busy_q[wb_addr]) begin
            busy_d[wb_addr] = 1'b0;
        end
        // Set after the clear so a same-cycle reissue keeps the bit (new producer wins).
        if (issue_accept) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_count_d = CW'($countones(busy_d));
    end

    // Writeback to the operand this cycle bypasses the hazard.
    always_comb begin
        rs_hazard = idx_ok(rs_addr) && busy_q[rs_addr] && !(wb_en && (wb_addr == rs_addr));
        rt_hazard = idx_ok(rt_addr) && busy_q[rt_addr] && !(wb_en && (wb_addr == rt_addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_onehot_q <= '0;
            dec_valid_q  <= 1'b0;
            busy_q       <= '0;
            busy_count_q <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            dec_onehot_q <= dec_onehot_d;
            dec_valid_q  <= dec_valid_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign dec_onehot = dec_onehot_q;
    assign dec_valid  = dec_valid_q;
    assign busy       = busy_q;
    assign busy_count = busy_count_q;
    assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_decoder_scoreboard.sv
// Directed bench: registered outputs are checked by a negedge monitor against a queue of
// hand-computed expectations; combinational outputs are checked right after each drive.
module tb_decoder_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_en, issue_en, wb_en;
    logic [3:0]  dec_addr, issue_addr, wb_addr, rs_addr, rt_addr;

    logic [15:0] dec_onehot0, busy0, dec_onehot1, busy1;
    logic        dec_valid0, issue_stall0, wb_err0, rs_hazard0, rt_hazard0;
    logic        dec_valid1, issue_stall1, wb_err1, rs_hazard1, rt_hazard1;
    logic [4:0]  busy_count0, busy_count1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] dec0;
        logic [15:0] dec1;
        logic        dv;
        logic [15:0] busy;
        logic [4:0]  cnt;
        logic        werr;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    // dut0 only exercises the decoder with index 0 decodable.
    decoder_scoreboard #(.ADDR_W(4), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .dec_en(dec_en), .dec_addr(dec_addr), .dec_onehot(dec_onehot0), .dec_valid(dec_valid0),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_stall(issue_stall0),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_err(wb_err0),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_hazard(rs_hazard0), .rt_hazard(rt_hazard0),
        .busy(busy0), .busy_count(busy_count0)
    );

    decoder_scoreboard #(.ADDR_W(4), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .dec_en(dec_en), .dec_addr(dec_addr), .dec_onehot(dec_onehot1), .dec_valid(dec_valid1),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_stall(issue_stall1),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_err(wb_err1),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_hazard(rs_hazard1), .rt_hazard(rt_hazard1),
        .busy(busy1), .busy_count(busy_count1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; x_* are the expected results for this vector.
    task automatic step(
        input logic ie, input logic [3:0] ia, input logic we, input logic [3:0] wa,
        input logic [3:0] rs, input logic [3:0] rt, input logic de, input logic [3:0] da,
        input logic x_stall, input logic x_rs, input logic x_rt,
        input logic [15:0] x_busy, input logic [4:0] x_cnt, input logic x_werr
    );
        exp_t e;
        @(negedge clk);
        #1;
        issue_en = ie; issue_addr = ia; wb_en = we; wb_addr = wa;
        rs_addr = rs; rt_addr = rt; dec_en = de; dec_addr = da;
        e.dec0 = de ? (16'd1 << da) : 16'd0;
        e.dec1 = (de && da != 4'd0) ? (16'd1 << da) : 16'd0;
        e.dv   = de;
        e.busy = x_busy;
        e.cnt  = x_cnt;
        e.werr = x_werr;
        exp_q.push_back(e);
        #1;
        check("issue_stall", 32'(issue_stall1), 32'(x_stall));
        check("rs_hazard", 32'(rs_hazard1), 32'(x_rs));
        check("rt_hazard", 32'(rt_hazard1), 32'(x_rt));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dec_onehot0", 32'(dec_onehot0), 32'(e.dec0));
                check("dec_valid0", 32'(dec_valid0), 32'(e.dv));
                check("dec_onehot1", 32'(dec_onehot1), 32'(e.dec1));
                check("dec_valid1", 32'(dec_valid1), 32'(e.dv));
                check("busy", 32'(busy1), 32'(e.busy));
                check("busy_count", 32'(busy_count1), 32'(e.cnt));
                check("wb_err", 32'(wb_err1), 32'(e.werr));
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0;
        dec_en = 1'b0; issue_en = 1'b0; wb_en = 1'b0;
        dec_addr = '0; issue_addr = '0; wb_addr = '0; rs_addr = '0; rt_addr = '0;
        #2;
        check("rst_busy", 32'(busy1), 32'h0);
        check("rst_count", 32'(busy_count1), 32'h0);
        check("rst_dec", 32'(dec_onehot0), 32'h0);
        check("rst_dec_valid", 32'(dec_valid0), 32'h0);
        check("rst_wb_err", 32'(wb_err1), 32'h0);
        #10 rst_n = 1'b1;

        // Decode sweep, then decode idle.
        for (int a = 0; a < 16; a++) begin
            step(0, 0, 0, 0, 0, 0, 1, 4'(a), 0, 0, 0, 16'h0000, 5'd0, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 4'd6, 0, 0, 0, 16'h0000, 5'd0, 0);

        // Issue 5, hazard next cycle, then writeback bypass.
        step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0020, 5'd1, 0);
        step(0, 0, 0, 0, 5, 5, 0, 0, 0, 1, 1, 16'h0020, 5'd1, 0);
        step(0, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0, 16'h0000, 5'd0, 0);

        // Double issue of 7 stalls the second.
        step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0080, 5'd1, 0);
        step(1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0080, 5'd1, 0);

        // Simultaneous issue + wb on busy 3 (decode runs in parallel).
        step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0088, 5'd2, 0);
        step(1, 3, 1, 3, 3, 7, 1, 4'd12, 0, 0, 1, 16'h0088, 5'd2, 0);

        // Spurious writeback to 9: one-cycle error pulse.
        step(0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 16'h0088, 5'd2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0088, 5'd2, 0);

        // Index 0 is ignored by the scoreboard.
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0088, 5'd2, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0088, 5'd2, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0088, 5'd2, 0);

        // Fill more entries, leaving decode output live.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h008a, 5'd3, 0);
        step(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h008e, 5'd4, 0);
        step(1, 4, 0, 0, 0, 7, 1, 4'd9, 0, 0, 1, 16'h009e, 5'd5, 0);

        // Asynchronous reset between edges with an issue in flight.
        @(negedge clk);
        #1;
        issue_en = 1'b1; issue_addr = 4'd5; dec_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy1), 32'h0);
        check("async_count", 32'(busy_count1), 32'h0);
        check("async_dec", 32'(dec_onehot1), 32'h0);
        check("async_dec_valid", 32'(dec_valid1), 32'h0);
        check("async_wb_err", 32'(wb_err1), 32'h0);
        issue_en = 1'b0;
        #1 rst_n = 1'b1;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 5'd0, 0);
        step(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0040, 5'd1, 0);
        step(0, 0, 0, 0, 9, 6, 0, 0, 0, 0, 1, 16'h0040, 5'd1, 0);

        repeat (3) @(posedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
